dct_da_ctrl: RTL and testbench
==============================

// Module: dct_da_ctrl
// PURPOSE
//  Sequencer for the 8-point distributed-arithmetic (DA) DCT ahead of the RLE stage.
//  Collects 8 EEG samples and forms the butterfly sums and differences.
//  Walks the bit planes MSB-first, driving chip-select and addresses of the 8 coefficient ROMs (Z0..Z7).
//  Shift-accumulates the ROM outputs into 8 DCT coefficients and hands them on with a valid/ready handshake.
// PARAMETERS
//  DW     8    input sample width, signed two's complement
//  ROM_W  17   ROM data width (signed Q2.14, sign-extended)
//  ACC_W  26   accumulator/coef width; must be >= ROM_W+DW+1
// PORTS
//  clk            in   1      system clock
//  rst_n          in   1      asynchronous active-low reset
//  in_valid       in   1      sample valid
//  in_ready       out  1      sample accepted when in_valid&in_ready
//  in_data        in   DW     signed sample, x0 first .. x7 last
//  rom_cs         out  1      chip select to all 8 ROMs
//  rom_addr_even  out  3      address to ROMs Z0,Z2,Z4,Z6
//  rom_addr_odd   out  3      address to ROMs Z1,Z3,Z5,Z7
//  rom_data_zK    in   ROM_W  data from ROM ZK, K=0..7 (8 ports)
//  out_valid      out  1      coefficient block valid
//  out_ready      in   1      downstream accepts block
//  coef_zK        out  ACC_W  DCT coefficient K, K=0..7 (8 ports)
//  busy           out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset (async assert): state=IDLE, sample_cnt=0, plane_cnt=0, accumulators=0.
//   in_ready=0, rom_cs=0, rom addrs=0, out_valid=0, coef_zK=0, busy=0.
//  FSM: IDLE -> LOAD -> BFLY -> CALC -> OUT -> LOAD.
//   IDLE: one cycle after reset release, then go to LOAD. This covers the ROM reset-sync cycle.
//   LOAD: in_ready=1. Each handshake stores x[sample_cnt] and increments sample_cnt.
//    When the 8th sample is accepted, sample_cnt wraps to 0 and the FSM goes to BFLY.
//   BFLY (1 cycle): s_i=x_i+x_(7-i), d_i=x_i-x_(7-i), i=0..3, each DW+1 bits. Accumulators cleared.
//   CALC (DW+1 cycles, plane j=DW..0, MSB first): rom_cs=1.
//    Even pattern {p0..p3} = bit j of {s0..s3}; odd pattern = bit j of {d0..d3}.
//    Address: p0 ? ~{p1,p2,p3} : {p1,p2,p3}. Negate flag n=p0 (one flag per even/odd group).
//    ROM data is read combinationally in the same cycle.
//    Term t = n ? -rom_data : rom_data, sign-extended to ACC_W.
//    Accumulate: acc <= (acc<<1) + t; on the sign plane (j=DW) use acc <= -t instead.
//    After plane 0, go to OUT.
//   OUT: coef_zK=acc_K, held stable, out_valid=1, in_ready=0.
//    On out_valid&out_ready: out_valid=0, go to LOAD. The stall is unbounded.
//  Latency: from 8th sample accepted to out_valid = DW+2 cycles (10 at DW=8).
//  rom_cs=0 and rom addrs=0 outside CALC (ROM power gating).
//  in_ready=0 in BFLY, CALC and OUT. No overlap between blocks (single-buffered).
//  Width rules:
//   Butterfly is computed in DW+1 bits, so no overflow.
//   Negation of ROM_W data is done in ROM_W+1 bits.
//   The accumulator never wraps for ACC_W >= ROM_W+DW+1.
//  Reset mid-operation: partial block is discarded, no out_valid. Restart from IDLE and x0.
//  in_valid with in_ready=0: sample is not consumed; the source must hold it.
//  coef_zK keeps its last value after the handshake until the next OUT.
// STRUCTURE
//  Package dct_da_pkg: DW, ROM_W, ACC_W, state enum {IDLE,LOAD,BFLY,CALC,OUT}, DA address/negate function.
//  Sub-module dct_da_acc: one accumulator lane (term negate, sign-plane subtract, shift-add).
//   Instantiated 8x: 4 lanes share the even negate flag, 4 lanes share the odd negate flag.
//  ROMs are external; the top level wires them to rom_cs and rom_addr_even/rom_addr_odd.
// TESTING
//  1. Reset, then 8 zero samples -> out_valid 10 cycles after the 8th accept; all coef_zK=0.
//  2. DC block, all x=1 -> s=2, d=0. rom_addr_even=000 on all planes, negate only on plane 1.
//     Result: coef_z6=0, odd coefs=0, coef_z0 matches the golden model.
//  3. Random signed samples incl. -128 and 127 -> all 8 coefs bit-exact against the DA golden model.
//  4. Hold out_ready=0 for 20 cycles -> coefs stable, in_ready=0, no samples accepted.
//     Release -> the next block loads normally.
//  5. Assert rst_n low in CALC plane 4 -> all outputs 0 immediately.
//     The next 8 samples produce a correct, uncorrupted block.
//  6. Gapped in_valid (1 of 3 cycles) -> sample order preserved. rom_cs high for exactly 9 cycles per block.

Source files
------------

// File: rtl/dct_da_pkg.sv
// rtl/dct_da_pkg.sv - shared widths, FSM states and DA address helper for dct_da_ctrl
// Purpose: constants and types used by the DA DCT sequencer and its accumulator lanes.
package dct_da_pkg;

  localparam int DW      = 8;   // input sample width, signed
  localparam int ROM_W   = 17;  // ROM data width, signed Q2.14
  localparam int ACC_W   = 26;  // accumulator / coefficient width
  localparam int PLANE_W = $clog2(DW + 1);

  // Plane index of the butterfly sign bit, walked first.
  localparam logic [PLANE_W-1:0] SIGN_PLANE = PLANE_W'(DW);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BFLY,
    CALC,
    OUT
  } state_e;

  // p[0]..p[3] are bit j of u0..u3. The ROMs only hold the half of the table
  // with p0=0; the other half is the negated mirror image, so fold the address
  // and raise the negate flag. Returns {negate, addr[2:0]}.
  function automatic logic [3:0] da_addr_neg(input logic [3:0] p);
    logic [2:0] a;
    a = {p[1], p[2], p[3]};
    return {p[0], (p[0] ? ~a : a)};
  endfunction

endpackage

// File: rtl/dct_da_acc.sv
// rtl/dct_da_acc.sv - one DA shift-accumulate lane
// Purpose: turns a ROM word into a signed term and folds it into a running
//   MSB-first bit-plane sum.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        clear accumulator (butterfly cycle)
//   en_i         accumulate this cycle (one bit plane)
//   sign_i       current plane is the sign plane
//   neg_i        negate the ROM word (folded address half)
//   rom_data_i   ROM word, signed ROM_W bits
//   acc_nxt_o    accumulator next value, lets the top capture the final sum
//                in the same edge that completes the last plane
module dct_da_acc
  import dct_da_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             sign_i,
  input  logic             neg_i,
  input  logic [ROM_W-1:0] rom_data_i,
  output logic [ACC_W-1:0] acc_nxt_o
);

  logic [ROM_W:0]   rom_ext;
  logic [ROM_W:0]   term;
  logic [ACC_W-1:0] term_ext;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // One extra bit so that negating the most negative ROM word cannot wrap.
  assign rom_ext  = {rom_data_i[ROM_W-1], rom_data_i};
  assign term     = neg_i ? (-rom_ext) : rom_ext;
  assign term_ext = {{(ACC_W - ROM_W - 1){term[ROM_W]}}, term};

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      // The sign plane carries weight -2^DW; starting with -t and doubling on
      // every later plane produces that weight.
      if (sign_i) begin
        acc_d = -term_ext;
      end else begin
        acc_d = (acc_q << 1) + term_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_nxt_o = acc_d;

endmodule

// File: rtl/dct_da_ctrl.sv
// rtl/dct_da_ctrl.sv - 8-point distributed-arithmetic DCT sequencer
// Purpose: collects 8 signed samples, forms butterfly sums/differences, walks
//   the bit planes MSB-first driving 8 external coefficient ROMs, and
//   accumulates 8 DCT coefficients handed off with valid/ready.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_ready/in_data      sample stream, x0 first
//   rom_cs                         chip select to all ROMs (CALC only)
//   rom_addr_even/rom_addr_odd     addresses for Z0,Z2,Z4,Z6 / Z1,Z3,Z5,Z7
//   rom_data_z0..z7                ROM read data, same-cycle
//   out_valid/out_ready            coefficient block handshake
//   coef_z0..z7                    coefficients, held until the next block
//   busy                           high outside IDLE
module dct_da_ctrl
  import dct_da_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             rom_cs,
  output logic [2:0]       rom_addr_even,
  output logic [2:0]       rom_addr_odd,
  input  logic [ROM_W-1:0] rom_data_z0,
  input  logic [ROM_W-1:0] rom_data_z1,
  input  logic [ROM_W-1:0] rom_data_z2,
  input  logic [ROM_W-1:0] rom_data_z3,
  input  logic [ROM_W-1:0] rom_data_z4,
  input  logic [ROM_W-1:0] rom_data_z5,
  input  logic [ROM_W-1:0] rom_data_z6,
  input  logic [ROM_W-1:0] rom_data_z7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] coef_z0,
  output logic [ACC_W-1:0] coef_z1,
  output logic [ACC_W-1:0] coef_z2,
  output logic [ACC_W-1:0] coef_z3,
  output logic [ACC_W-1:0] coef_z4,
  output logic [ACC_W-1:0] coef_z5,
  output logic [ACC_W-1:0] coef_z6,
  output logic [ACC_W-1:0] coef_z7,
  output logic             busy
);

  state_e state_q, state_d;

  logic [2:0]         sample_cnt_q;
  logic [PLANE_W-1:0] plane_q;
  logic [DW-1:0]      x_q [8];
  logic [DW:0]        s_q [4];
  logic [DW:0]        d_q [4];
  logic [ACC_W-1:0]   coef_q [8];
  logic [ACC_W-1:0]   acc_nxt [8];
  logic [ROM_W-1:0]   rom_data [8];

  logic       accept;
  logic       last_plane;
  logic [3:0] p_even, p_odd;
  logic [3:0] an_even, an_odd;

  assign accept     = in_valid & in_ready;
  assign last_plane = (plane_q == '0);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    rom_cs    = 1'b0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    case (state_q)
      // Single idle cycle gives the ROMs their reset-sync cycle.
      IDLE: state_d = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (accept && (sample_cnt_q == 3'd7)) begin
          state_d = BFLY;
        end
      end
      BFLY: state_d = CALC;
      CALC: begin
        rom_cs = 1'b1;
        if (last_plane) begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      plane_q      <= '0;
      for (int i = 0; i < 8; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        s_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        x_q[sample_cnt_q] <= in_data;
        sample_cnt_q      <= sample_cnt_q + 3'd1;
      end
      if (state_q == BFLY) begin
        for (int i = 0; i < 4; i++) begin
          s_q[i] <= {x_q[i][DW-1], x_q[i]} + {x_q[7-i][DW-1], x_q[7-i]};
          d_q[i] <= {x_q[i][DW-1], x_q[i]} - {x_q[7-i][DW-1], x_q[7-i]};
        end
        plane_q <= SIGN_PLANE;
      end
      if (state_q == CALC) begin
        if (last_plane) begin
          for (int k = 0; k < 8; k++) begin
            coef_q[k] <= acc_nxt[k];
          end
        end else begin
          plane_q <= plane_q - 1'b1;
        end
      end
    end
  end

  always_comb begin
    p_even = '0;
    p_odd  = '0;
    for (int i = 0; i < 4; i++) begin
      p_even[i] = s_q[i][plane_q];
      p_odd[i]  = d_q[i][plane_q];
    end
  end

  assign an_even = da_addr_neg(p_even);
  assign an_odd  = da_addr_neg(p_odd);

  // Addresses are forced to zero outside CALC so the ROM pins stay quiet.
  assign rom_addr_even = rom_cs ? an_even[2:0] : 3'b000;
  assign rom_addr_odd  = rom_cs ? an_odd[2:0]  : 3'b000;

  assign rom_data[0] = rom_data_z0;
  assign rom_data[1] = rom_data_z1;
  assign rom_data[2] = rom_data_z2;
  assign rom_data[3] = rom_data_z3;
  assign rom_data[4] = rom_data_z4;
  assign rom_data[5] = rom_data_z5;
  assign rom_data[6] = rom_data_z6;
  assign rom_data[7] = rom_data_z7;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    dct_da_acc u_acc (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (state_q == BFLY),
      .en_i       (state_q == CALC),
      .sign_i     (plane_q == SIGN_PLANE),
      .neg_i      ((k % 2 == 0) ? an_even[3] : an_odd[3]),
      .rom_data_i (rom_data[k]),
      .acc_nxt_o  (acc_nxt[k])
    );
  end

  assign coef_z0 = coef_q[0];
  assign coef_z1 = coef_q[1];
  assign coef_z2 = coef_q[2];
  assign coef_z3 = coef_q[3];
  assign coef_z4 = coef_q[4];
  assign coef_z5 = coef_q[5];
  assign coef_z6 = coef_q[6];
  assign coef_z7 = coef_q[7];

endmodule

// File: tb/tb_dct_da_ctrl.sv
// tb/tb_dct_da_ctrl.sv - self-checking scoreboard bench for dct_da_ctrl
module tb_dct_da_ctrl;

  localparam int DW    = 8;
  localparam int ROM_W = 17;
  localparam int ACC_W = 26;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             rom_cs;
  logic [2:0]       rom_addr_even, rom_addr_odd;
  logic [ROM_W-1:0] rom_data_z0, rom_data_z1, rom_data_z2, rom_data_z3;
  logic [ROM_W-1:0] rom_data_z4, rom_data_z5, rom_data_z6, rom_data_z7;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] coef_z0, coef_z1, coef_z2, coef_z3;
  logic [ACC_W-1:0] coef_z4, coef_z5, coef_z6, coef_z7;
  logic             busy;

  always #5 clk = ~clk;

  dct_da_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rom_cs(rom_cs), .rom_addr_even(rom_addr_even), .rom_addr_odd(rom_addr_odd),
    .rom_data_z0(rom_data_z0), .rom_data_z1(rom_data_z1),
    .rom_data_z2(rom_data_z2), .rom_data_z3(rom_data_z3),
    .rom_data_z4(rom_data_z4), .rom_data_z5(rom_data_z5),
    .rom_data_z6(rom_data_z6), .rom_data_z7(rom_data_z7),
    .out_valid(out_valid), .out_ready(out_ready),
    .coef_z0(coef_z0), .coef_z1(coef_z1), .coef_z2(coef_z2), .coef_z3(coef_z3),
    .coef_z4(coef_z4), .coef_z5(coef_z5), .coef_z6(coef_z6), .coef_z7(coef_z7),
    .busy(busy)
  );

  // Coefficient rows: even K applies to s0..s3, odd K to d0..d3. All entries
  // even so the offset-binary ROM words below are integers.
  int C [8][4] = '{
    '{4000, 4000, 4000, 4000},
    '{5800, 4000, -2600, -7200},
    '{5000, 2000, -2000, -5000},
    '{4000, -6000, 8000, -6000},
    '{3000, -3000, -3000, 3000},
    '{2600, -7200, 5800, -1200},
    '{2000, -5000, 5000, -2000},
    '{1200, -2600, 4000, -2600}
  };

  // Offset-binary DA table: ROM[a] = sum_i C_i*(p_i - 1/2) with p0=0,
  // {p1,p2,p3} = a. Its mirror symmetry is what makes address folding valid,
  // and a full MSB-first walk yields sum_i C_i*u_i + (sum_i C_i)/2.
  function automatic logic [ROM_W-1:0] rom_val(input int k, input logic [2:0] a);
    int v;
    v = -C[k][0] + (a[2] ? C[k][1] : -C[k][1]) + (a[1] ? C[k][2] : -C[k][2])
        + (a[0] ? C[k][3] : -C[k][3]);
    v = v / 2;
    return v[ROM_W-1:0];
  endfunction

  assign rom_data_z0 = rom_cs ? rom_val(0, rom_addr_even) : '0;
  assign rom_data_z1 = rom_cs ? rom_val(1, rom_addr_odd)  : '0;
  assign rom_data_z2 = rom_cs ? rom_val(2, rom_addr_even) : '0;
  assign rom_data_z3 = rom_cs ? rom_val(3, rom_addr_odd)  : '0;
  assign rom_data_z4 = rom_cs ? rom_val(4, rom_addr_even) : '0;
  assign rom_data_z5 = rom_cs ? rom_val(5, rom_addr_odd)  : '0;
  assign rom_data_z6 = rom_cs ? rom_val(6, rom_addr_even) : '0;
  assign rom_data_z7 = rom_cs ? rom_val(7, rom_addr_odd)  : '0;

  // ROM-pin monitor (written only here).
  int cs_cnt   = 0;
  int nz_even  = 0;
  int nz_odd   = 0;
  int bad_gate = 0;
  always @(negedge clk) begin
    if (rom_cs) begin
      cs_cnt = cs_cnt + 1;
      if (rom_addr_even != 3'b000) nz_even = nz_even + 1;
      if (rom_addr_odd  != 3'b000) nz_odd  = nz_odd + 1;
    end else if (rom_addr_even != 3'b000 || rom_addr_odd != 3'b000) begin
      bad_gate = bad_gate + 1;
    end
  end

  int     n_tests = 0;
  int     n_fail  = 0;
  longint exp_q[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_expected(input int x[8]);
    int     s[4], d[4];
    longint acc, sum;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] + x[7-i];
      d[i] = x[i] - x[7-i];
    end
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        acc += longint'(C[k][i]) * ((k % 2 == 0) ? s[i] : d[i]);
        sum += C[k][i];
      end
      exp_q.push_back(acc + sum / 2);
    end
  endtask

  // Drive 8 samples with 'gap' idle cycles before each; returns just after
  // the edge that accepted the 8th sample.
  task automatic send_block(input int x[8], input int gap);
    logic ok;
    int   t;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = DW'(x[i]);
      ok = 1'b0;
      t  = 0;
      while (!ok && t < 100) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!ok) check("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    push_expected(x);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_timeout", out_valid, 1);
  endtask

  task automatic check_block();
    longint g[8];
    g[0] = $signed(coef_z0); g[1] = $signed(coef_z1);
    g[2] = $signed(coef_z2); g[3] = $signed(coef_z3);
    g[4] = $signed(coef_z4); g[5] = $signed(coef_z5);
    g[6] = $signed(coef_z6); g[7] = $signed(coef_z7);
    if (exp_q.size() < 8) begin
      check("scoreboard_underflow", exp_q.size(), 8);
    end else begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("coef_z%0d", k), g[k], exp_q.pop_front());
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_drop", out_valid, 0);
  endtask

  task automatic run_block(input int x[8], input int gap);
    int cs0, lat;
    cs0 = cs_cnt;
    send_block(x, gap);
    wait_out(lat);
    check("latency", lat, 10);
    check("rom_cs_cycles", cs_cnt - cs0, 9);
    check_block();
  endtask

  int xb[8];
  int lat, ne0, no0;
  longint hold_c3, hold_c4;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_rom_cs", rom_cs, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_coef_z0", coef_z0, 0);
    check("rst_addr", {rom_addr_even, rom_addr_odd}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("idle_in_ready", in_ready, 0);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;
    check("load_in_ready", in_ready, 1);
    check("load_busy", busy, 1);

    // 1. all-zero block
    xb = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_block(xb, 0);

    // 2. DC block: s=2, d=0, every ROM address stays at 000
    xb = '{1, 1, 1, 1, 1, 1, 1, 1};
    ne0 = nz_even;
    no0 = nz_odd;
    run_block(xb, 0);
    check("dc_addr_even_nz", nz_even - ne0, 0);
    check("dc_addr_odd_nz", nz_odd - no0, 0);
    check("dc_z0_held", $signed(coef_z0), 40000);
    check("dc_z6_held", $signed(coef_z6), 0);
    check("dc_z1_held", $signed(coef_z1), 0);
    check("dc_z7_held", $signed(coef_z7), 0);

    // 3. extremes and random signed samples
    xb = '{-128, 127, -128, 127, -128, 127, -128, 127};
    run_block(xb, 0);
    xb = '{-128, -128, -128, -128, -128, -128, -128, -128};
    run_block(xb, 0);
    xb = '{127, 127, 127, 127, 127, 127, 127, 127};
    run_block(xb, 0);
    repeat (3) begin
      for (int i = 0; i < 8; i++) xb[i] = int'($urandom_range(0, 255)) - 128;
      run_block(xb, 0);
    end

    // 4. downstream stall for 20 cycles with a source waiting
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) xb[i] = int'($urandom_range(0, 255)) - 128;
    send_block(xb, 0);
    wait_out(lat);
    check("stall_latency", lat, 10);
    hold_c3 = $signed(coef_z3);
    hold_c4 = $signed(coef_z4);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_coef_z3", $signed(coef_z3), hold_c3);
    end
    check("stall_coef_z4", $signed(coef_z4), hold_c4);
    in_valid = 1'b0;
    check_block();
    xb = '{10, -20, 30, -40, 50, -60, 70, -80};
    run_block(xb, 0);

    // 5. reset while CALC is on plane 4
    xb = '{-5, 17, 99, -100, 3, 64, -77, 120};
    send_block(xb, 0);
    repeat (5) @(posedge clk);
    #1;
    check("midrst_rom_cs", rom_cs, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_rom_cs_low", rom_cs, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_addr", {rom_addr_even, rom_addr_odd}, 0);
    check("midrst_coef_z0", coef_z0, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    xb = '{33, -33, 100, -1, 0, 127, -128, 7};
    run_block(xb, 0);

    // 6. gapped source, one valid every third cycle
    for (int i = 0; i < 8; i++) xb[i] = int'($urandom_range(0, 255)) - 128;
    run_block(xb, 2);
    xb = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_block(xb, 2);

    check("scoreboard_leftover", exp_q.size(), 0);
    check("rom_addr_gating", bad_gate, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
